// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the BRAM port-B arbiter.
package bram_arb_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // The starve count must hold values up to 15.
   localparam int unsigned STARVE_W = 4;

   // Tag for a read in flight. It follows the 1-cycle BRAM read latency.
   typedef struct packed {
      logic valid;
      logic master;
   } rd_tag_t;

endpackage

// File: rtl/bram_b_arbiter_if.sv
// Request/response bundle for one master of the port-B arbiter.
interface bram_b_arbiter_if #(
   parameter int unsigned AW = 9
);
   logic          req;
   logic          we_h;
   logic          we_l;
   logic [AW-1:0] addr;
   logic [15:0]   din;
   logic          gnt;
   logic          rvalid;
   logic [15:0]   rdata;

   modport master (
      output req, we_h, we_l, addr, din,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we_h, we_l, addr, din,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear. Clear has priority over increment.
module sat_counter #(
   parameter int unsigned   W   = 4,
   parameter logic [W-1:0]  MAX = '1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_count
);
   logic [W-1:0] r_count;

   // Count register: clear, otherwise increment until MAX is reached.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;
endmodule

// File: rtl/bram_b_arbiter.sv
// Two-master arbiter for BRAM port B. Master 0 is the CPU. Master 1 is the debug/loader
// engine, which can lock the port. Port B is driven combinationally from the winner.
// Read data is routed back one cycle later using a tag.
// Optional: define BRAM_ARB_STATS_EN to build the grant/conflict statistics counters.
module bram_b_arbiter
   import bram_arb_pkg::*;
#(
   parameter int unsigned AW           = 9,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned STAT_W       = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   bram_b_arbiter_if.slave     m0_bus,
   bram_b_arbiter_if.slave     m1_bus,
   input  logic                i_m1_lock,
   output logic                o_b_en,
   output logic                o_b_we_h,
   output logic                o_b_we_l,
   output logic [AW-1:0]       o_b_addr,
   output logic [7:0]          o_b_din_h,
   output logic [7:0]          o_b_din_l,
   input  logic [7:0]          i_b_dout_h,
   input  logic [7:0]          i_b_dout_l,
   output logic [STAT_W-1:0]   o_stat_m0_gnt,
   output logic [STAT_W-1:0]   o_stat_m1_gnt,
   output logic [STAT_W-1:0]   o_stat_conflict,
   output logic                o_m1_owned
);
   localparam logic [STARVE_W-1:0] LP_STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   arb_state_e            r_state;
   arb_state_e            w_state_next;
   rd_tag_t               r_tag;
   logic [15:0]           r_m0_rdata;
   logic [15:0]           r_m1_rdata;
   logic [STARVE_W-1:0]   w_starve_cnt;
   logic                  w_starved;
   logic                  w_gnt0;
   logic                  w_gnt1;
   logic                  w_b_en;
   logic                  w_we_h;
   logic                  w_we_l;
   logic                  w_rd;
   logic                  w_m0_rvalid;
   logic                  w_m1_rvalid;
   logic [15:0]           w_dout;

   assign w_starved = (w_starve_cnt == LP_STARVE_MAX);

   // Grant decision and next state. A held lock shuts out master 0. When the lock drops,
   // the normal priority rules apply in that same cycle.
   always_comb begin
      w_gnt0       = 1'b0;
      w_gnt1       = 1'b0;
      w_state_next = r_state;
      if ((r_state == LOCK) && i_m1_lock) begin
         w_gnt1 = m1_bus.req;
      end else begin
         if (m0_bus.req && m1_bus.req) begin
            w_gnt1 = w_starved;
            w_gnt0 = !w_starved;
         end else begin
            w_gnt0 = m0_bus.req;
            w_gnt1 = m1_bus.req;
         end
         w_state_next = (w_gnt1 && i_m1_lock) ? LOCK : ARB;
      end
      if (i_rst) begin
         w_gnt0 = 1'b0;
         w_gnt1 = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ARB;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Count the cycles in which master 1 requests and is denied.
   sat_counter #(
      .W   (STARVE_W),
      .MAX (LP_STARVE_MAX)
   ) u_starve (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (m1_bus.req && !w_gnt1),
      .i_clr   (!m1_bus.req || w_gnt1),
      .o_count (w_starve_cnt)
   );

   assign w_b_en = w_gnt0 || w_gnt1;
   assign w_we_h = w_b_en && (w_gnt1 ? m1_bus.we_h : m0_bus.we_h);
   assign w_we_l = w_b_en && (w_gnt1 ? m1_bus.we_l : m0_bus.we_l);
   assign w_rd   = w_b_en && !w_we_h && !w_we_l;

   assign o_b_en    = w_b_en;
   assign o_b_we_h  = w_we_h;
   assign o_b_we_l  = w_we_l;
   assign o_b_addr  = w_gnt1 ? m1_bus.addr : m0_bus.addr;
   assign o_b_din_h = w_gnt1 ? m1_bus.din[15:8] : m0_bus.din[15:8];
   assign o_b_din_l = w_gnt1 ? m1_bus.din[7:0] : m0_bus.din[7:0];

   assign m0_bus.gnt = w_gnt0;
   assign m1_bus.gnt = w_gnt1;
   assign o_m1_owned = (r_state == LOCK);

   // Read tag: records who issued the read that the BRAM answers next cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tag <= '0;
      end else begin
         r_tag <= '{valid: w_rd, master: (w_gnt1 ? M1 : M0)};
      end
   end

   assign w_dout      = {i_b_dout_h, i_b_dout_l};
   assign w_m0_rvalid = r_tag.valid && (r_tag.master == M0);
   assign w_m1_rvalid = r_tag.valid && (r_tag.master == M1);

   // Hold registers, so rdata keeps the last delivered word between reads.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_m0_rdata <= '0;
         r_m1_rdata <= '0;
      end else begin
         if (w_m0_rvalid) r_m0_rdata <= w_dout;
         if (w_m1_rvalid) r_m1_rdata <= w_dout;
      end
   end

   assign m0_bus.rvalid = w_m0_rvalid;
   assign m1_bus.rvalid = w_m1_rvalid;
   assign m0_bus.rdata  = w_m0_rvalid ? w_dout : r_m0_rdata;
   assign m1_bus.rdata  = w_m1_rvalid ? w_dout : r_m1_rdata;

`ifdef BRAM_ARB_STATS_EN
   logic w_conflict;

   // Conflict: both masters request, or master 0 is shut out by a held lock.
   assign w_conflict = m0_bus.req && (m1_bus.req || ((r_state == LOCK) && i_m1_lock));

   sat_counter #(.W(STAT_W)) u_stat_m0 (
      .i_clk(i_clk), .i_rst(i_rst), .i_inc(w_gnt0), .i_clr(1'b0), .o_count(o_stat_m0_gnt)
   );
   sat_counter #(.W(STAT_W)) u_stat_m1 (
      .i_clk(i_clk), .i_rst(i_rst), .i_inc(w_gnt1), .i_clr(1'b0), .o_count(o_stat_m1_gnt)
   );
   sat_counter #(.W(STAT_W)) u_stat_cf (
      .i_clk(i_clk), .i_rst(i_rst), .i_inc(w_conflict && !i_rst), .i_clr(1'b0),
      .o_count(o_stat_conflict)
   );
`else
   assign o_stat_m0_gnt   = '0;
   assign o_stat_m1_gnt   = '0;
   assign o_stat_conflict = '0;
`endif
endmodule

// File: tb/tb_bram_b_arbiter.sv
// Bench for bram_b_arbiter with a behavioural byte-enabled BRAM on port B.
// Expected read data is queued when a grant is checked. A monitor pops each entry when
// rvalid is seen. The monitor also reports late, missing or stray rvalid pulses.
module tb_bram_b_arbiter;
   localparam int unsigned AW = 9;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        m1_lock;
   logic        b_en, b_we_h, b_we_l;
   logic [8:0]  b_addr;
   logic [7:0]  b_din_h, b_din_l;
   logic [15:0] b_dout;
   logic [15:0] stat_m0, stat_m1, stat_cf;
   logic        m1_owned;
   logic [15:0] mem [0:511];
   logic        mem_loaded = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int exp_g0 = 0;
   int exp_g1 = 0;
   int exp_cf = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t e;

   bram_b_arbiter_if #(.AW(AW)) m0_bus ();
   bram_b_arbiter_if #(.AW(AW)) m1_bus ();

   bram_b_arbiter #(.AW(AW), .STARVE_LIMIT(4), .STAT_W(16)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .m0_bus          (m0_bus),
      .m1_bus          (m1_bus),
      .i_m1_lock       (m1_lock),
      .o_b_en          (b_en),
      .o_b_we_h        (b_we_h),
      .o_b_we_l        (b_we_l),
      .o_b_addr        (b_addr),
      .o_b_din_h       (b_din_h),
      .o_b_din_l       (b_din_l),
      .i_b_dout_h      (b_dout[15:8]),
      .i_b_dout_l      (b_dout[7:0]),
      .o_stat_m0_gnt   (stat_m0),
      .o_stat_m1_gnt   (stat_m1),
      .o_stat_conflict (stat_cf),
      .o_m1_owned      (m1_owned)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // BRAM model: registered read of the old word, with byte write enables. It is loaded
   // once at the first edge: word i = 0x1000+i, except words 0 and 3, which are 0xF000.
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 512; i++) mem[i] <= 16'h1000 + 16'(i);
         mem[0] <= 16'hF000;
         mem[3] <= 16'hF000;
         mem_loaded <= 1'b1;
      end else if (b_en) begin
         if (b_we_h) mem[b_addr][15:8] <= b_din_h;
         if (b_we_l) mem[b_addr][7:0] <= b_din_l;
         b_dout <= mem[b_addr];
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: checks every rvalid pulse against the queue, and flags expected pulses that
   // never came.
   always @(negedge clk) begin
      if (m0_bus.rvalid === 1'b1) begin
         if (q0.size() == 0) chk("m0_rvalid_stray", 16'd1, 16'd0);
         else begin
            e = q0.pop_front();
            chk("m0_rvalid_cycle", 16'(cyc), 16'(e.cyc));
            chk("m0_rdata", m0_bus.rdata, e.data);
         end
      end
      if (q0.size() > 0 && q0[0].cyc < cyc) begin
         void'(q0.pop_front());
         chk("m0_rvalid_missing", 16'd0, 16'd1);
      end
      if (m1_bus.rvalid === 1'b1) begin
         if (q1.size() == 0) chk("m1_rvalid_stray", 16'd1, 16'd0);
         else begin
            e = q1.pop_front();
            chk("m1_rvalid_cycle", 16'(cyc), 16'(e.cyc));
            chk("m1_rdata", m1_bus.rdata, e.data);
         end
      end
      if (q1.size() > 0 && q1[0].cyc < cyc) begin
         void'(q1.pop_front());
         chk("m1_rvalid_missing", 16'd0, 16'd1);
      end
   end

   // One request cycle. we = {we_h, we_l}. eg0/eg1/eo are the expected grants and ownership.
   // x0/x1 are the read data to expect one cycle later.
   task automatic drive(input string nm,
                        input logic r0, input logic [1:0] we0, input logic [8:0] a0,
                        input logic [15:0] d0,
                        input logic r1, input logic [1:0] we1, input logic [8:0] a1,
                        input logic [15:0] d1,
                        input logic lk, input logic eg0, input logic eg1, input logic eo,
                        input logic [15:0] x0, input logic [15:0] x1);
      m0_bus.req = r0; m0_bus.we_h = we0[1]; m0_bus.we_l = we0[0];
      m0_bus.addr = a0; m0_bus.din = d0;
      m1_bus.req = r1; m1_bus.we_h = we1[1]; m1_bus.we_l = we1[0];
      m1_bus.addr = a1; m1_bus.din = d1;
      m1_lock = lk;
      @(negedge clk);
      chk({nm, "_gnt0"}, 16'(m0_bus.gnt), 16'(eg0));
      chk({nm, "_gnt1"}, 16'(m1_bus.gnt), 16'(eg1));
      chk({nm, "_owned"}, 16'(m1_owned), 16'(eo));
      chk({nm, "_b_en"}, 16'(b_en), 16'(eg0 | eg1));
      if (eg0 && we0 == 2'b00) q0.push_back('{cyc + 1, x0});
      if (eg1 && we1 == 2'b00) q1.push_back('{cyc + 1, x1});
      if (eg0) exp_g0++;
      if (eg1) exp_g1++;
      if (r0 && (r1 || (eo && lk))) exp_cf++;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_gnt0"}, 16'(m0_bus.gnt), 16'd0);
      chk({nm, "_gnt1"}, 16'(m1_bus.gnt), 16'd0);
      chk({nm, "_b_en"}, 16'(b_en), 16'd0);
      chk({nm, "_we"}, 16'({b_we_h, b_we_l}), 16'd0);
      chk({nm, "_rvalid"}, 16'({m0_bus.rvalid, m1_bus.rvalid}), 16'd0);
      chk({nm, "_rdata0"}, m0_bus.rdata, 16'd0);
      chk({nm, "_rdata1"}, m1_bus.rdata, 16'd0);
      chk({nm, "_owned"}, 16'(m1_owned), 16'd0);
      chk({nm, "_stats"}, stat_m0 | stat_m1 | stat_cf, 16'd0);
   endtask

   task automatic idle(input string nm, input logic eo);
      drive(nm, 0, 2'b00, 9'd0, 16'h0, 0, 2'b00, 9'd0, 16'h0, 0, 0, 0, eo, 16'h0, 16'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no end expected end");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with both masters requesting: nothing is granted.
      rst = 1'b1;
      m0_bus.req = 1; m0_bus.we_h = 0; m0_bus.we_l = 0; m0_bus.addr = 9'd3; m0_bus.din = 0;
      m1_bus.req = 1; m1_bus.we_h = 0; m1_bus.we_l = 0; m1_bus.addr = 9'd2; m1_bus.din = 0;
      m1_lock = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("rst");
      m0_bus.req = 0; m1_bus.req = 0;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Plain read of word 3.
      drive("rd3", 1, 2'b00, 9'd3, 16'h0, 0, 2'b00, 9'd0, 16'h0, 0, 1, 0, 0, 16'hF000, 16'h0);
      idle("idle0", 0);
      // High-byte write by m1, then m0 reads the same word.
      drive("m1_wr0", 0, 2'b00, 9'd0, 16'h0, 1, 2'b10, 9'd0, 16'hAB12, 0, 0, 1, 0, 16'h0, 16'h0);
      drive("m0_rd0", 1, 2'b00, 9'd0, 16'h0, 0, 2'b00, 9'd0, 16'h0, 0, 1, 0, 0, 16'hAB00, 16'h0);
      // Low-byte write by m0, then m1 reads the same word.
      drive("m0_wr6", 1, 2'b01, 9'd6, 16'h55AA, 0, 2'b00, 9'd0, 16'h0, 0, 1, 0, 0, 16'h0, 16'h0);
      drive("m1_rd6", 0, 2'b00, 9'd0, 16'h0, 1, 2'b00, 9'd6, 16'h0, 0, 0, 1, 0, 16'h0, 16'h10AA);
      // Back-to-back reads by different masters.
      drive("m0_rd1", 1, 2'b00, 9'd1, 16'h0, 0, 2'b00, 9'd0, 16'h0, 0, 1, 0, 0, 16'h1001, 16'h0);
      drive("m1_rd2", 0, 2'b00, 9'd0, 16'h0, 1, 2'b00, 9'd2, 16'h0, 0, 0, 1, 0, 16'h0, 16'h1002);
      // Continuous contention: m1 wins every fifth cycle.
      for (int i = 0; i < 10; i++) begin
         drive("starve", 1, 2'b00, 9'd4, 16'h0, 1, 2'b00, 9'd5, 16'h0, 0,
               (i % 5) != 4, (i % 5) == 4, 0, 16'h1004, 16'h1005);
      end
      idle("idle1", 0);
      // Lock: m1 takes the port, then keeps it for six cycles against m0.
      drive("lock_go", 0, 2'b00, 9'd0, 16'h0, 1, 2'b00, 9'd7, 16'h0, 1, 0, 1, 0, 16'h0, 16'h1007);
      for (int i = 0; i < 6; i++) begin
         drive("lock_hold", 1, 2'b00, 9'd8, 16'h0, 1, 2'b00, 9'd7, 16'h0, 1,
               0, 1, 1, 16'h0, 16'h1007);
      end
      drive("lock_drop", 1, 2'b00, 9'd8, 16'h0, 0, 2'b00, 9'd0, 16'h0, 0, 1, 0, 1,
            16'h1008, 16'h0);
      idle("idle2", 0);
`ifdef BRAM_ARB_STATS_EN
      chk("stat_m0", stat_m0, 16'(exp_g0));
      chk("stat_m1", stat_m1, 16'(exp_g1));
      chk("stat_conflict", stat_cf, 16'(exp_cf));
`else
      chk("stat_m0", stat_m0, 16'd0);
      chk("stat_m1", stat_m1, 16'd0);
      chk("stat_conflict", stat_cf, 16'd0);
`endif
      // Reset arrives mid-cycle while an m0 read is pending: that rvalid must never appear.
      m0_bus.req = 1; m0_bus.we_h = 0; m0_bus.we_l = 0; m0_bus.addr = 9'd9;
      @(negedge clk);
      chk("pre_rst_gnt0", 16'(m0_bus.gnt), 16'd1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("mid_rst");
      m0_bus.req = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      idle("post_rst0", 0);
      idle("post_rst1", 0);
      drive("rd3_again", 1, 2'b00, 9'd3, 16'h0, 0, 2'b00, 9'd0, 16'h0, 0, 1, 0, 0,
            16'hF000, 16'h0);
      idle("idle3", 0);
      idle("idle4", 0);
      chk("q0_drained", 16'(q0.size()), 16'd0);
      chk("q1_drained", 16'(q1.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
